// File: rtl/rv_imm_pkg.sv
// Shared encodings for the immediate decode stage: immediate type codes,
// RV base opcodes that carry immediates, and the skid buffer state set.
package rv_imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_R = 3'b101,
        IMM_Z = 3'b110
    } imm_type_e;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_e;

endpackage

// File: rtl/imm_sel_ext_xlen.sv
// Combinational opcode classifier and immediate extender.
// Optional feature macro: IMM_CSR_ZIMM_EN -- when defined, CSR immediate
// forms (SYSTEM with funct3[2]=1) report type Z and a zero-extended rs1 field.
module imm_sel_ext_xlen
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0] opcode;
    imm_type_e  sel;
    logic       bad;
    logic [31:0] raw;

    assign opcode   = instr[6:0];
    assign imm_type = sel;
    assign illegal  = bad;

    // Classify the opcode into an immediate type; unknown opcodes fall back to R with illegal set
    always_comb begin
        sel = IMM_R;
        bad = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC:           sel = IMM_U;
            OP_JAL:                     sel = IMM_J;
            OP_JALR, OP_LOAD, OP_OPIMM: sel = IMM_I;
            OP_SYSTEM: begin
                sel = IMM_I;
`ifdef IMM_CSR_ZIMM_EN
                if (instr[14]) begin
                    sel = IMM_Z;
                end
`endif
            end
            OP_BRANCH:                  sel = IMM_B;
            OP_STORE:                   sel = IMM_S;
            OP_OP:                      sel = IMM_R;
            OP_OPIMM32: begin
                if (XLEN == 64) sel = IMM_I;
                else            bad = 1'b1;
            end
            OP_OP32: begin
                if (XLEN == 64) sel = IMM_R;
                else            bad = 1'b1;
            end
            default:                    bad = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        if (bad) begin
            sel = IMM_R;
        end
    end

    // Assemble the 32-bit immediate for the selected format, already sign-extended to 32 bits
    always_comb begin
        raw = 32'd0;
        case (sel)
            IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: raw = {instr[31:12], 12'd0};
            IMM_J: raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: raw = 32'd0;
        endcase
    end

    // Widen to XLEN: sign-extend from bit 31, except the CSR immediate which is zero-extended
    always_comb begin
        imm = {XLEN{raw[31]}};
        imm[31:0] = raw;
        if (sel == IMM_Z) begin
            imm = '0;
            imm[4:0] = instr[19:15];
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage: decodes on the input side and buffers decoded
// results in a two-entry (out + skid) buffer behind a valid/ready handshake.
// in_ready depends only on registered state, never on out_ready.
// Optional feature macro: IMM_CSR_ZIMM_EN (handled inside imm_sel_ext_xlen).
module imm_decode_stage
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    buf_state_e state;
    buf_state_e next_state;

    logic [2:0]      dec_type;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic [2:0]      skid_type;
    logic [XLEN-1:0] skid_imm;
    logic            skid_illegal;

    logic accept;
    logic drain;
    logic load_out_from_in;
    logic load_out_from_skid;
    logic load_skid;

    imm_sel_ext_xlen #(
        .XLEN (XLEN)
    ) u_sel_ext (
        .instr    (in_instr),
        .imm_type (dec_type),
        .imm      (dec_imm),
        .illegal  (dec_illegal)
    );

    assign in_ready  = ~rst & (state != BUF_TWO);
    assign out_valid = (state != BUF_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // Next buffer state and which registers load; flush empties the buffer and drops the incoming word
    always_comb begin
        next_state         = state;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        if (flush) begin
            next_state = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        next_state       = BUF_ONE;
                        load_out_from_in = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && !drain) begin
                        next_state = BUF_TWO;
                        load_skid  = 1'b1;
                    end else if (accept && drain) begin
                        load_out_from_in = 1'b1;
                    end else if (drain) begin
                        next_state = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        next_state         = BUF_ONE;
                        load_out_from_skid = 1'b1;
                    end
                end
                default: next_state = BUF_EMPTY;
            endcase
        end
    end

    // Buffer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Output and skid data registers; reset clears every data field
    always_ff @(posedge clk) begin
        if (rst) begin
            out_instr    <= '0;
            out_pc       <= '0;
            out_type     <= '0;
            out_imm      <= '0;
            out_illegal  <= 1'b0;
            skid_instr   <= '0;
            skid_pc      <= '0;
            skid_type    <= '0;
            skid_imm     <= '0;
            skid_illegal <= 1'b0;
        end else begin
            if (load_out_from_in) begin
                out_instr   <= in_instr;
                out_pc      <= in_pc;
                out_type    <= dec_type;
                out_imm     <= dec_imm;
                out_illegal <= dec_illegal;
            end else if (load_out_from_skid) begin
                out_instr   <= skid_instr;
                out_pc      <= skid_pc;
                out_type    <= skid_type;
                out_imm     <= skid_imm;
                out_illegal <= skid_illegal;
            end
            if (load_skid) begin
                skid_instr   <= in_instr;
                skid_pc      <= in_pc;
                skid_type    <= dec_type;
                skid_imm     <= dec_imm;
                skid_illegal <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed testbench for imm_decode_stage. Drives one XLEN=32 and one
// XLEN=64 instance with identical stimulus and checks hand-computed results.
// Optional feature macro: IMM_CSR_ZIMM_EN changes the expected CSR decode.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [63:0] in_pc64;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  out_type;
    logic [31:0] out_imm;
    logic        out_illegal;

    logic        in_ready64;
    logic        out_valid64;
    logic [31:0] out_instr64;
    logic [63:0] out_pc64;
    logic [2:0]  out_type64;
    logic [63:0] out_imm64;
    logic        out_illegal64;

    int compared   = 0;
    int mismatched = 0;

    imm_decode_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_type    (out_type),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .in_instr    (in_instr),
        .in_pc       (in_pc64),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .out_instr   (out_instr64),
        .out_pc      (out_pc64),
        .out_type    (out_type64),
        .out_imm     (out_imm64),
        .out_illegal (out_illegal64)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic ordy,
                                 input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        in_pc64   = {32'd0, pc};
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Single transfer into an empty stage with out_ready high; checks latency and decode
    task automatic singleTransfer(input string tag, input logic [31:0] instr,
                                  input logic [31:0] pc, input logic [2:0] exp_type,
                                  input logic [63:0] exp_imm32,
                                  input logic [63:0] exp_imm64);
        applyStimulus(1'b1, instr, pc, 1'b1, 1'b0);
        checkOutput({tag, "_pre_valid"}, {63'd0, out_valid}, 64'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        checkOutput({tag, "_type"}, {61'd0, out_type}, {61'd0, exp_type});
        checkOutput({tag, "_imm"}, {32'd0, out_imm}, exp_imm32);
        checkOutput({tag, "_imm64"}, out_imm64, exp_imm64);
        checkOutput({tag, "_illegal"}, {63'd0, out_illegal}, 64'd0);
        checkOutput({tag, "_pc"}, {32'd0, out_pc}, {32'd0, pc});
        tick();
        checkOutput({tag, "_drained"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("rst_imm", {32'd0, out_imm}, 64'd0);
        checkOutput("rst_instr", {32'd0, out_instr}, 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();

        // One of each immediate format
        singleTransfer("addi", 32'h5dc00093, 32'h0000_0100, 3'b000, 64'h0000_05dc, 64'h0000_0000_0000_05dc);
        singleTransfer("sw",   32'h001127a3, 32'h0000_0104, 3'b001, 64'h0000_000f, 64'h0000_0000_0000_000f);
        singleTransfer("beq",  32'hfe208ee3, 32'h0000_0108, 3'b010, 64'hffff_fffc, 64'hffff_ffff_ffff_fffc);
        singleTransfer("lui",  32'h001000b7, 32'h0000_010c, 3'b011, 64'h0010_0000, 64'h0000_0000_0010_0000);
        singleTransfer("jal",  32'h000010ef, 32'h0000_0110, 3'b100, 64'h0000_1000, 64'h0000_0000_0000_1000);
`ifdef IMM_CSR_ZIMM_EN
        singleTransfer("csrrwi", 32'h3002d0f3, 32'h0000_0114, 3'b110, 64'h0000_0005, 64'h0000_0000_0000_0005);
`else
        singleTransfer("csrrwi", 32'h3002d0f3, 32'h0000_0114, 3'b000, 64'h0000_0300, 64'h0000_0000_0000_0300);
`endif

        // OP-IMM-32: illegal at XLEN=32, I-type at XLEN=64
        applyStimulus(1'b1, 32'h0000001b, 32'h0000_0118, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("w32_illegal", {63'd0, out_illegal}, 64'd1);
        checkOutput("w32_type", {61'd0, out_type}, 64'd5);
        checkOutput("w32_imm", {32'd0, out_imm}, 64'd0);
        checkOutput("w64_illegal", {63'd0, out_illegal64}, 64'd0);
        checkOutput("w64_type", {61'd0, out_type64}, 64'd0);
        tick();

        // Low opcode bits not 11 is illegal on both widths
        applyStimulus(1'b1, 32'hfff00090, 32'h0000_011c, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("c_illegal", {63'd0, out_illegal}, 64'd1);
        checkOutput("c_imm64", out_imm64, 64'd0);
        tick();

        // Back-pressure: four instructions with out_ready low
        applyStimulus(1'b1, 32'h00100093, 32'h0000_0200, 1'b0, 1'b0);
        checkOutput("bp_ready_a", {63'd0, in_ready}, 64'd1);
        tick();
        applyStimulus(1'b1, 32'h00200113, 32'h0000_0204, 1'b0, 1'b0);
        checkOutput("bp_ready_b", {63'd0, in_ready}, 64'd1);
        tick();
        applyStimulus(1'b1, 32'h00300193, 32'h0000_0208, 1'b0, 1'b0);
        checkOutput("bp_full_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("bp_full_imm", {32'd0, out_imm}, 64'd1);
        tick();
        checkOutput("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("bp_hold_imm", {32'd0, out_imm}, 64'd1);
        checkOutput("bp_hold_pc", {32'd0, out_pc}, 64'h200);
        applyStimulus(1'b1, 32'h00300193, 32'h0000_0208, 1'b1, 1'b0);
        tick();
        checkOutput("bp_second_imm", {32'd0, out_imm}, 64'd2);
        checkOutput("bp_second_ready", {63'd0, in_ready}, 64'd1);
        tick();
        checkOutput("bp_third_imm", {32'd0, out_imm}, 64'd3);
        applyStimulus(1'b1, 32'h00400213, 32'h0000_020c, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("bp_fourth_imm", {32'd0, out_imm}, 64'd4);
        checkOutput("bp_fourth_pc64", out_pc64, 64'h20c);
        tick();
        checkOutput("bp_empty", {63'd0, out_valid}, 64'd0);

        // Flush while TWO with a new instruction offered
        applyStimulus(1'b1, 32'h00500293, 32'h0000_0300, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00600313, 32'h0000_0304, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00700393, 32'h0000_0308, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("flush_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("flush_ready", {63'd0, in_ready}, 64'd1);
        tick();
        checkOutput("flush_gone", {63'd0, out_valid}, 64'd0);

        // Reset in ONE, then resume normally
        applyStimulus(1'b1, 32'h5dc00093, 32'h0000_0400, 1'b0, 1'b0);
        tick();
        checkOutput("one_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("mrst_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("mrst_imm", {32'd0, out_imm}, 64'd0);
        checkOutput("mrst_pc", {32'd0, out_pc}, 64'd0);
        checkOutput("mrst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        tick();
        singleTransfer("jal_after_rst", 32'h000010ef, 32'h0000_0500, 3'b100, 64'h0000_1000, 64'h0000_0000_0000_1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
